wide_add_sequencer: RTL and testbench
=====================================

Name: wide_add_sequencer

Overview:
- Multi-cycle controller that performs a (WORDS×16)-bit addition by sequencing one shared s16_bit_adder instance over WORDS cycles.
- Each cycle adds one 16-bit word, LSW first, and registers the carry between words.
- Sits beside the ALU datapath as the wide-operand add unit.
- Uses a start/busy/done handshake and a registered result.

Parameters:
- WORDS, 4, number of 16-bit words per operand (legal 2..16). Total width W = 16*WORDS.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request an operation; sampled only in IDLE
- a  input  W  operand A; latched on the accepted start
- b  input  W  operand B; latched on the accepted start
- carry_in  input  1  carry-in to word 0; latched on the accepted start
- sub  input  1  exists only with WIDE_SUB_EN; 1 = subtract; latched on start
- sum  output  W  registered result
- carry_out  output  1  carry out of the top word
- overflow  output  1  signed overflow of the full-width result
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset state: state=IDLE, idx=0, carry register=0, operand registers=0. Outputs sum=0, carry_out=0, overflow=0, busy=0, done=0.
- Reset mid-operation aborts immediately and restores all of the above. No partial result is retained.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge k:
  - latch a, b, carry_in (and sub);
  - carry register ← initial carry;
  - idx ← 0;
  - state → RUN.
- IDLE, start=0: hold. sum, carry_out and overflow keep the last result.
- RUN, each edge:
  - adder inputs: A word idx, B_eff word idx, carry register;
  - sum word idx ← adder sum;
  - carry register ← adder carry_out;
  - idx ← idx+1.
  - On the edge where idx==WORDS-1: carry_out ← adder carry_out; overflow computed; state → DONE.
- DONE: done=1 for exactly one cycle, then → IDLE on the next edge.
- Latency: start accepted at edge k → done high during the cycle after edge k+WORDS. Throughput is one operation per WORDS+2 cycles.
- start while busy=1 (RUN or DONE) is ignored and not queued. start held continuously begins a new operation on the first IDLE edge.
- Operand inputs may change freely after the accepting edge. Only the latched copies are used.
- Result stability:
  - sum words not yet written keep their previous-operation values until overwritten;
  - the full sum is valid from the done cycle until the next accepted start;
  - carry_out and overflow update only at the final word.
- Overflow: overflow = (A[W-1] == B_eff[W-1]) && (sum[W-1] != A[W-1]).
- Without WIDE_SUB_EN: B_eff = B and initial carry = carry_in.
- Arithmetic: modulo 2^W; {carry_out, sum} = A + B_eff + initial carry.
- idx width is $clog2(WORDS). idx is never compared beyond WORDS-1.

Optional Feature:
- WIDE_SUB_EN defined:
  - sub port present;
  - sub=1 gives B_eff = ~B and initial carry = ~carry_in, so sum = A − B − carry_in (carry_in acts as borrow-in);
  - carry_out = 1 means no borrow;
  - sub=0 behaves as plain add.
- WIDE_SUB_EN undefined: no sub port, add only, no inversion logic.

Decomposition:
- Shared package/header:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - WORD_W=16;
  - WORDS legality check constant.
- Sub-module: exactly one instance of the existing s16_bit_adder as the word datapath. Word-select muxing and the carry register live in the sequencer.

Test Plan (WORDS=4):
- Reset: assert rst_n=0 mid-RUN (after 2 RUN edges) → next cycle all outputs 0, state IDLE; a following start completes normally.
- Full carry ripple: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, carry_in=0 → done 5 edges after start; sum=0, carry_out=1, overflow=0.
- Signed overflow: a=64'h7FFF_FFFF_FFFF_FFFF, b=1 → sum=64'h8000_0000_0000_0000, carry_out=0, overflow=1.
- Carry-in and busy: a=64'h0000_0001_0000_FFFF, b=0, carry_in=1, start pulsed again in RUN and in DONE → only one done pulse; sum=64'h0000_0001_0001_0000.
- Back-to-back: start held high across two operations → second accepted on the first IDLE edge after DONE; done pulses are WORDS+2=6 cycles apart; the first result is stable between the pulses.
- WIDE_SUB_EN: sub=1, a=5, b=7, carry_in=0 → sum=64'hFFFF_FFFF_FFFF_FFFE, carry_out=0 (borrow), overflow=0.

Source files
------------

// File: rtl/wide_add_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wide_add_sequencer_pkg
//  Description : Shared definitions for the wide add sequencer: FSM state
//                encoding, datapath word width and the legal WORDS range.
//  Contents    : state_e   - IDLE / RUN / DONE encoding
//                WORD_W    - width of one datapath word (16)
//                words_legal() - range check for the WORDS parameter
//  Revision    : 1.0 - initial release
// ============================================================================
package wide_add_sequencer_pkg;

  localparam int WORD_W    = 16;
  localparam int MIN_WORDS = 2;
  localparam int MAX_WORDS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Elaboration-time check used by the top to reject out-of-range WORDS.
  function automatic bit words_legal(input int words);
    return (words >= MIN_WORDS) && (words <= MAX_WORDS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/s16_bit_adder.sv
`default_nettype none
// ============================================================================
//  Module      : s16_bit_adder
//  Description : 16-bit combinational adder with carry-in and carry-out.
//                Word datapath shared by the wide add sequencer.
//  Ports       : a, b       in  16  addends
//                carry_in   in   1  carry into bit 0
//                sum        out 16  a + b + carry_in (mod 2^16)
//                carry_out  out  1  carry out of bit 15
//  Revision    : 1.0 - initial release
// ============================================================================
module s16_bit_adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carry_in,
  output logic [15:0] sum,
  output logic        carry_out
);

  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {16'd0, carry_in};

endmodule
`default_nettype wire

// File: rtl/wide_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : wide_add_sequencer
//  Description : Performs a (WORDS*16)-bit addition by stepping one shared
//                s16_bit_adder across the operands, least significant word
//                first, with the inter-word carry held in a register.
//                start/busy/done handshake, registered result.
//  Parameters  : WORDS      number of 16-bit words per operand (2..16)
//  Ports       : clk        in   1  rising-edge clock
//                rst_n      in   1  asynchronous active-low reset
//                start      in   1  request; sampled only in IDLE
//                a, b       in   W  operands, latched on accepted start
//                carry_in   in   1  carry into word 0 (borrow-in when sub=1)
//                sub        in   1  subtract select (WIDE_SUB_EN builds only)
//                sum        out  W  registered result
//                carry_out  out  1  carry out of the top word
//                overflow   out  1  signed overflow of the full result
//                busy       out  1  high in RUN and DONE
//                done       out  1  one-cycle completion pulse
//  Build macro : WIDE_SUB_EN - adds the sub port and A - B - borrow mode
//  Revision    : 1.0 - initial release
// ============================================================================
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter  int WORDS = 4,
  localparam int W     = WORD_W * WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         carry_in,
`ifdef WIDE_SUB_EN
  input  logic         sub,
`endif
  output logic [W-1:0] sum,
  output logic         carry_out,
  output logic         overflow,
  output logic         busy,
  output logic         done
);

  localparam int                IDX_W    = $clog2(WORDS);
  localparam int                WORD_SH  = $clog2(WORD_W);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

  generate
    if (!words_legal(WORDS)) begin : g_words_illegal
      $error("wide_add_sequencer: WORDS must be in 2..16");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Effective operand B and initial carry. Subtraction is A + ~B + ~borrow,
  // so inversion is folded in before latching and the RUN datapath is the
  // same for both modes.
  // --------------------------------------------------------------------------
  logic [W-1:0] b_eff_in;
  logic         carry_init;

`ifdef WIDE_SUB_EN
  assign b_eff_in   = sub ? ~b : b;
  assign carry_init = carry_in ^ sub;
`else
  assign b_eff_in   = b;
  assign carry_init = carry_in;
`endif

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e           state_q,     state_d;
  logic [IDX_W-1:0] idx_q,       idx_d;
  logic [W-1:0]     a_q,         a_d;
  logic [W-1:0]     b_q,         b_d;
  logic             carry_q,     carry_d;
  logic [W-1:0]     sum_q,       sum_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q,  overflow_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;

  // --------------------------------------------------------------------------
  // Word datapath: select word idx of each latched operand.
  // --------------------------------------------------------------------------
  logic [IDX_W+WORD_SH-1:0] word_lsb;
  logic [WORD_W-1:0]        a_word;
  logic [WORD_W-1:0]        b_word;
  logic [WORD_W-1:0]        add_sum;
  logic                     add_cout;

  assign word_lsb = {idx_q, {WORD_SH{1'b0}}};
  assign a_word   = a_q[word_lsb +: WORD_W];
  assign b_word   = b_q[word_lsb +: WORD_W];

  s16_bit_adder u_word_adder (
    .a         (a_word),
    .b         (b_word),
    .carry_in  (carry_q),
    .sum       (add_sum),
    .carry_out (add_cout)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b_eff_in;
          carry_d = carry_init;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Only the current word is written; higher words keep the previous
        // operation's values until their turn comes.
        sum_d[word_lsb +: WORD_W] = add_sum;
        carry_d                   = add_cout;
        idx_d                     = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          carry_out_d = add_cout;
          // Operand sign bits are the top bits of the latched words; the
          // result sign is the MSB of the top word being written now.
          overflow_d  = (a_q[W-1] == b_q[W-1]) && (add_sum[WORD_W-1] != a_q[W-1]);
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_wide_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wide_add_sequencer
//  Description : Directed self-checking bench for wide_add_sequencer with
//                WORDS=4 (64-bit operands). Expected values are hand-computed.
//                Build with WIDE_SUB_EN defined to include the subtract case.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wide_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 64;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         start    = 1'b0;
  logic [W-1:0] a        = '0;
  logic [W-1:0] b        = '0;
  logic         carry_in = 1'b0;
`ifdef WIDE_SUB_EN
  logic         sub      = 1'b0;
`endif
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  wide_add_sequencer #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
`ifdef WIDE_SUB_EN
    .sub       (sub),
`endif
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .busy      (busy),
    .done      (done)
  );

  // Counts done pulses, sampled mid-cycle.
  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulses start for one accepting edge and waits (bounded) for done.
  // Returns the number of falling edges from start assertion to done (-1 on
  // timeout). Leaves the caller at the falling edge where done is high.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic icin, output int lat);
    @(negedge clk);
    a = ia; b = ib; carry_in = icin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, c0, first, second;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    chk("rst_sum",  sum,       64'd0);
    chk("rst_cout", carry_out, 64'd0);
    chk("rst_ovf",  overflow,  64'd0);
    chk("rst_busy", busy,      64'd0);
    chk("rst_done", done,      64'd0);
    rst_n = 1'b1;

    // ---------------- full carry ripple ----------------
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, lat);
    chk("ripple_lat",  lat,       64'd5);
    chk("ripple_busy", busy,      64'd1);
    chk("ripple_sum",  sum,       64'h0);
    chk("ripple_cout", carry_out, 64'd1);
    chk("ripple_ovf",  overflow,  64'd0);
    @(negedge clk);
    chk("ripple_done_pulse", done, 64'd0);
    chk("ripple_idle_busy",  busy, 64'd0);

    // ---------------- signed overflow ----------------
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, lat);
    chk("ovf_lat",  lat,       64'd5);
    chk("ovf_sum",  sum,       64'h8000_0000_0000_0000);
    chk("ovf_cout", carry_out, 64'd0);
    chk("ovf_ovf",  overflow,  64'd1);

    // ---------------- carry-in, start ignored while busy ----------------
    @(posedge clk);
    c0 = done_cnt;
    @(negedge clk);
    a = 64'h0000_0001_0000_FFFF; b = 64'd0; carry_in = 1'b1; start = 1'b1;
    @(negedge clk);                      // RUN
    start = 1'b0;
    a = 64'hDEAD_BEEF_DEAD_BEEF;         // latched copy must be used
    chk("cin_busy_run", busy, 64'd1);
    @(negedge clk); start = 1'b1;        // pulse during RUN
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);                      // DONE cycle
    chk("cin_done", done, 64'd1);
    chk("cin_busy_done", busy, 64'd1);
    start = 1'b1;                        // pulse during DONE
    @(negedge clk);
    start = 1'b0;
    chk("cin_idle_busy", busy, 64'd0);
    repeat (10) @(negedge clk);
    @(posedge clk);
    chk("cin_one_pulse", done_cnt - c0, 64'd1);
    chk("cin_sum",  sum,       64'h0000_0001_0001_0000);
    chk("cin_cout", carry_out, 64'd0);

    // ---------------- reset mid-RUN ----------------
    @(negedge clk);
    a = 64'h1234; b = 64'd1; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);                      // two RUN edges done
    rst_n = 1'b0;
    #1;
    chk("mrst_sum",  sum,       64'd0);
    chk("mrst_cout", carry_out, 64'd0);
    chk("mrst_ovf",  overflow,  64'd0);
    chk("mrst_busy", busy,      64'd0);
    chk("mrst_done", done,      64'd0);
    @(negedge clk);
    chk("mrst_held_busy", busy, 64'd0);
    rst_n = 1'b1;
    run_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, lat);
    chk("post_rst_lat",  lat,       64'd5);
    chk("post_rst_sum",  sum,       64'h1234_5678_9ABC_DF00);
    chk("post_rst_cout", carry_out, 64'd0);
    chk("post_rst_ovf",  overflow,  64'd0);

    // ---------------- back-to-back with start held ----------------
    @(negedge clk);
    a = 64'd2; b = 64'd3; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 64'h8000_0000_0000_0000; b = 64'h8000_0000_0000_0000;
    first = -1; second = -1;
    for (int t = 1; t <= 30; t++) begin
      if (done) begin
        if (first < 0) begin
          first = t;
          chk("b2b_sum1",  sum,       64'd5);
          chk("b2b_cout1", carry_out, 64'd0);
        end else begin
          second = t;
          start  = 1'b0;
          break;
        end
      end else if (first >= 0 && t <= first + 2) begin
        chk("b2b_sum1_stable", sum, 64'd5);
      end
      @(negedge clk);
    end
    chk("b2b_seen_first", (first > 0), 64'd1);
    chk("b2b_gap",  second - first, 64'd6);
    chk("b2b_sum2",  sum,       64'd0);
    chk("b2b_cout2", carry_out, 64'd1);
    chk("b2b_ovf2",  overflow,  64'd1);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_stop_busy", busy, 64'd0);

`ifdef WIDE_SUB_EN
    // ---------------- subtract with borrow out ----------------
    sub = 1'b1;
    run_op(64'd5, 64'd7, 1'b0, lat);
    sub = 1'b0;
    chk("sub_lat",  lat,       64'd5);
    chk("sub_sum",  sum,       64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_cout", carry_out, 64'd0);
    chk("sub_ovf",  overflow,  64'd0);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
